cmd_bus_pin_ctrl: RTL and testbench
===================================

# cmd_bus_pin_ctrl

Responder endpoint on the chip-side command bus. It decodes timed write and read strobes issued by the command scheduler, holds a small register file, and drives one output pin as off, constant low or high, or a programmable square wave. One instance sits per controlled pin. Each instance is addressed by its `BASE_ADDR` page.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h01: address page matched against `cmd_bus_addr[15:8]`. Must not equal 8'hFF, which is reserved for the timer-reset broadcast.
- `CNT_W`, default 16: width of the phase counters and the `HIGH`/`LOW` registers.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_bus_addr`, in, 19: bus address. `[15:8]` is the page, `[7:0]` is the register offset, `[18:16]` is ignored.
- `cmd_bus_data`, in, 32: write data, sampled on the strobe edge.
- `cmd_bus_en`, in, 1: bus cycle enable, a single-cycle pulse.
- `cmd_bus_wr`, in, 1: write qualifier.
- `cmd_bus_rd`, in, 1: read qualifier.
- `rd_data`, out, 32: registered readback data.
- `rd_valid`, out, 1: one-cycle pulse marking `rd_data` valid.
- `pin_out`, out, 1: registered pin level.
- `pin_oe`, out, 1: pin output enable. 0 means tristate.

## Operation
- **Address match:** `hit = cmd_bus_en & (cmd_bus_addr[15:8] == BASE_ADDR) & (cmd_bus_addr[15:0] != 16'hFFFF)`.
- **Write registers:** a write is `hit & cmd_bus_wr`.
  - 0x00 `MODE` = `data[1:0]`: 0 OFF, 1 LOW, 2 HIGH, 3 SQUARE.
  - 0x01 `HIGH` = `data[CNT_W-1:0]`.
  - 0x02 `LOW` = `data[CNT_W-1:0]`.
  - 0x03 `CLR` (any data): zeroes `PERIODS`.
  - Writes to other offsets are ignored.
- **Read registers:** a read is `hit & cmd_bus_rd & ~cmd_bus_wr`.
  - 0x00 returns `{30'b0, MODE}`.
  - 0x01 returns `HIGH`, zero-extended.
  - 0x02 returns `LOW`, zero-extended.
  - 0x10 returns `STATUS = {29'b0, pin_oe, pin_out, state==SQ_HIGH}`.
  - 0x11 returns `PERIODS`, 32 bits.
  - Other offsets return 0.
- **Read/write conflict:** `rd` and `wr` asserted together count as a write only. No `rd_valid`.
- **State machine:** states OFF, CONST, SQ_HIGH, SQ_LOW.
  - MODE write 0 → OFF: `pin_oe=0`, `pin_out=0`.
  - MODE write 1 or 2 → CONST: `pin_oe=1`, `pin_out=MODE[1]`.
  - MODE write 3 → SQ_HIGH: `pin_out=1`, `cnt=eff(HIGH)-1`.
  - SQ_HIGH with `cnt==0` → SQ_LOW: `pin_out=0`, `cnt=eff(LOW)-1`.
  - SQ_LOW with `cnt==0` → SQ_HIGH: `pin_out=1`, `cnt=eff(HIGH)-1`, `PERIODS+1`.
  - Otherwise `cnt-1` each cycle.
- **`eff(x)`:** equals `x`, except `eff(0)=1`. So high phase = `eff(HIGH)` cycles, low phase = `eff(LOW)` cycles.
- **Re-writing MODE:** writing MODE, including the same value, restarts the state from its entry. MODE=3 always restarts at the beginning of the high phase.
- **HIGH/LOW writes while in SQUARE:** they do not disturb the running `cnt`. They take effect at the next phase reload.
- **`PERIODS`:** 32 bits, wraps 0xFFFFFFFF→0. A CLR write and a period completion in the same cycle gives `PERIODS=0`.

## Timing
- **Reset values:** state OFF, `MODE=0`, `HIGH=1`, `LOW=1`, `cnt=0`, `PERIODS=0`, `pin_out=0`, `pin_oe=0`, `rd_data=0`, `rd_valid=0`.
- **Reset mid-operation:** all of the above values apply immediately, asynchronously.
- **Write latency:** a strobe high during cycle N is captured at the rising edge ending cycle N. Registers, state, `pin_out` and `pin_oe` all update at that edge, giving one cycle of latency from strobe to pin.
- **Read latency:** a read in cycle N gives `rd_data` and `rd_valid=1` after the edge ending cycle N. `rd_valid` drops after the following edge. `rd_data` holds its value until the next read.
- **Read contents:** a read returns the register values from before the edge. Back-to-back reads give back-to-back `rd_valid` pulses.
- **Square wave period:** `eff(HIGH)+eff(LOW)` cycles. With `HIGH=LOW=1` the pin toggles every cycle.
- **No back-pressure:** every strobe is consumed in a single cycle.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `pin_oe=0`, `pin_out=0`, `rd_valid=0` immediately. Then read 0x01 → `rd_data=1`.
- **Constant modes:** write MODE=2 → `pin_oe=1`, `pin_out=1` one edge later. Write MODE=1 → `pin_out=0`. Write MODE=0 → `pin_oe=0`.
- **Square wave:** write HIGH=3, LOW=2, then MODE=3 → repeating pin pattern 1,1,1,0,0. After 4 periods, read 0x11 → 4.
- **Zero and update edge cases:** HIGH=0, LOW=0 → pin toggles every cycle. Change LOW to 5 during a high phase → the current high phase completes unchanged and the next low phase lasts 5 cycles.
- **Address decode:** write with page `BASE_ADDR+1`, with addr 16'hFFFF, and with `en=0` → no change in any register. Write to offset 0x07 → ignored. Read offset 0x07 → `rd_data=0`, `rd_valid=1`.
- **Conflicts and wrap:** `rd` and `wr` together on MODE=2 → mode changes and no `rd_valid`. Preload `PERIODS` to 0xFFFFFFFF via forced state, complete one period → reads 0. CLR coincident with a period completion → reads 0.

Source files
------------

// File: rtl/cmd_bus_pin_ctrl.sv
// Command-bus register endpoint driving one pin as off / constant / square wave.
// Writes reach the pin one edge after the strobe; reads are registered one cycle; no back-pressure.
module cmd_bus_pin_ctrl #(
   parameter logic [7:0]  BASE_ADDR = 8'h01,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [18:0] cmd_bus_addr,
   input  logic [31:0] cmd_bus_data,
   input  logic        cmd_bus_en,
   input  logic        cmd_bus_wr,
   input  logic        cmd_bus_rd,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        pin_out,
   output logic        pin_oe
);

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_CONST   = 2'd1,
      ST_SQ_HIGH = 2'd2,
      ST_SQ_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      periods_q, periods_d;
   logic             pin_out_q, pin_out_d;
   logic             pin_oe_q, pin_oe_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   logic             hit, wr_hit, rd_hit;
   logic [7:0]       offset;
   logic             unused_bits;

   assign unused_bits = ^{cmd_bus_addr[18:16], cmd_bus_data};

   // Page 0xFF is the timer-reset broadcast and never decodes here.
   assign hit    = cmd_bus_en && (cmd_bus_addr[15:8] == BASE_ADDR) && (cmd_bus_addr[15:0] != 16'hFFFF);
   assign wr_hit = hit && cmd_bus_wr;
   assign rd_hit = hit && cmd_bus_rd && !cmd_bus_wr;
   assign offset = cmd_bus_addr[7:0];

   // Reload value for a phase: a programmed length of 0 behaves as 1 cycle.
   function automatic logic [CNT_W-1:0] phase_reload(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : (len - CNT_ONE);
   endfunction

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      high_d     = high_q;
      low_d      = low_q;
      cnt_d      = cnt_q;
      periods_d  = periods_q;
      pin_out_d  = pin_out_q;
      pin_oe_d   = pin_oe_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      unique case (state_q)
         ST_SQ_HIGH: begin
            if (cnt_q == '0) begin
               state_d   = ST_SQ_LOW;
               pin_out_d = 1'b0;
               cnt_d     = phase_reload(low_q);
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_SQ_LOW: begin
            if (cnt_q == '0) begin
               state_d   = ST_SQ_HIGH;
               pin_out_d = 1'b1;
               cnt_d     = phase_reload(high_q);
               periods_d = periods_q + 32'd1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: ;
      endcase

      if (wr_hit) begin
         case (offset)
            8'h00: begin
               // Any MODE write restarts the selected behaviour from its entry point.
               mode_d    = cmd_bus_data[1:0];
               periods_d = periods_q;
               case (cmd_bus_data[1:0])
                  2'd0: begin
                     state_d   = ST_OFF;
                     pin_oe_d  = 1'b0;
                     pin_out_d = 1'b0;
                  end
                  2'd3: begin
                     state_d   = ST_SQ_HIGH;
                     pin_oe_d  = 1'b1;
                     pin_out_d = 1'b1;
                     cnt_d     = phase_reload(high_q);
                  end
                  default: begin
                     state_d   = ST_CONST;
                     pin_oe_d  = 1'b1;
                     pin_out_d = cmd_bus_data[1];
                  end
               endcase
            end
            8'h01:   high_d    = cmd_bus_data[CNT_W-1:0];
            8'h02:   low_d     = cmd_bus_data[CNT_W-1:0];
            8'h03:   periods_d = '0;
            default: ;
         endcase
      end

      if (rd_hit) begin
         rd_valid_d = 1'b1;
         case (offset)
            8'h00:   rd_data_d = {30'b0, mode_q};
            8'h01:   rd_data_d = 32'(high_q);
            8'h02:   rd_data_d = 32'(low_q);
            8'h10:   rd_data_d = {29'b0, pin_oe_q, pin_out_q, (state_q == ST_SQ_HIGH)};
            8'h11:   rd_data_d = periods_q;
            default: rd_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_OFF;
         mode_q     <= 2'd0;
         high_q     <= CNT_ONE;
         low_q      <= CNT_ONE;
         cnt_q      <= '0;
         periods_q  <= '0;
         pin_out_q  <= 1'b0;
         pin_oe_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         high_q     <= high_d;
         low_q      <= low_d;
         cnt_q      <= cnt_d;
         periods_q  <= periods_d;
         pin_out_q  <= pin_out_d;
         pin_oe_q   <= pin_oe_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign pin_out  = pin_out_q;
   assign pin_oe   = pin_oe_q;

endmodule

// File: tb/tb_cmd_bus_pin_ctrl.sv
// Directed bench for cmd_bus_pin_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_cmd_bus_pin_ctrl;

   localparam logic [7:0] BASE = 8'h01;

   logic        clk;
   logic        rst;
   logic [18:0] cmd_bus_addr;
   logic [31:0] cmd_bus_data;
   logic        cmd_bus_en;
   logic        cmd_bus_wr;
   logic        cmd_bus_rd;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        pin_out;
   logic        pin_oe;

   int checks   = 0;
   int failures = 0;

   cmd_bus_pin_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_bus_addr (cmd_bus_addr),
      .cmd_bus_data (cmd_bus_data),
      .cmd_bus_en   (cmd_bus_en),
      .cmd_bus_wr   (cmd_bus_wr),
      .cmd_bus_rd   (cmd_bus_rd),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .pin_out      (pin_out),
      .pin_oe       (pin_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: driven at a falling edge, captured at the next rising edge, returns at the following falling edge.
   task automatic bus(input logic [18:0] a, input logic [31:0] d, input logic e, input logic w, input logic r);
      cmd_bus_addr = a;
      cmd_bus_data = d;
      cmd_bus_en   = e;
      cmd_bus_wr   = w;
      cmd_bus_rd   = r;
      @(negedge clk);
      cmd_bus_en   = 1'b0;
      cmd_bus_wr   = 1'b0;
      cmd_bus_rd   = 1'b0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      bus({3'b000, BASE, off}, d, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
      bus({3'b000, BASE, off}, 32'h0, 1'b1, 1'b0, 1'b1);
      check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
      check(tag, rd_data, exp);
   endtask

   initial begin
      rst          = 1'b1;
      cmd_bus_addr = '0;
      cmd_bus_data = '0;
      cmd_bus_en   = 1'b0;
      cmd_bus_wr   = 1'b0;
      cmd_bus_rd   = 1'b0;

      #1;
      check("rst_pin_oe",   {31'b0, pin_oe},   32'd0);
      check("rst_pin_out",  {31'b0, pin_out},  32'd0);
      check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_rd_data",  rd_data,           32'd0);
      @(negedge clk);
      rst = 1'b0;

      rd_chk("rst_high",    8'h01, 32'd1);
      rd_chk("rst_low",     8'h02, 32'd1);
      rd_chk("rst_mode",    8'h00, 32'd0);
      rd_chk("rst_periods", 8'h11, 32'd0);

      // Constant modes
      wr(8'h00, 32'd2);
      check("m2_oe",  {31'b0, pin_oe},  32'd1);
      check("m2_out", {31'b0, pin_out}, 32'd1);
      rd_chk("m2_status", 8'h10, 32'd6);
      rd_chk("m2_mode",   8'h00, 32'd2);
      wr(8'h00, 32'd1);
      check("m1_oe",  {31'b0, pin_oe},  32'd1);
      check("m1_out", {31'b0, pin_out}, 32'd0);
      wr(8'h00, 32'd0);
      check("m0_oe",  {31'b0, pin_oe},  32'd0);
      check("m0_out", {31'b0, pin_out}, 32'd0);

      // Asynchronous reset in the middle of a cycle
      wr(8'h01, 32'd9);
      wr(8'h00, 32'd2);
      rd_chk("pre_rst_high", 8'h01, 32'd9);
      #2 rst = 1'b1;
      #1;
      check("arst_pin_oe",   {31'b0, pin_oe},   32'd0);
      check("arst_pin_out",  {31'b0, pin_out},  32'd0);
      check("arst_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("arst_rd_data",  rd_data,           32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("arst_high", 8'h01, 32'd1);

      // Square wave HIGH=3 LOW=2: 1,1,1,0,0 repeating
      wr(8'h01, 32'd3);
      wr(8'h02, 32'd2);
      wr(8'h00, 32'd3);
      check("sq_oe", {31'b0, pin_oe}, 32'd1);
      rd_chk("sq_status", 8'h10, 32'd7);
      for (int k = 1; k < 20; k++) begin
         check($sformatf("sq_pin_%0d", k), {31'b0, pin_out}, ((k % 5) < 3) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      rd_chk("sq_periods", 8'h11, 32'd4);

      // Zero lengths behave as one cycle
      wr(8'h01, 32'd0);
      wr(8'h02, 32'd0);
      wr(8'h00, 32'd3);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("zero_pin_%0d", k), {31'b0, pin_out}, ((k % 2) == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // LOW changed mid high phase: high stays 3, next low lasts 5
      wr(8'h01, 32'd3);
      wr(8'h02, 32'd2);
      wr(8'h00, 32'd3);
      check("upd_pin_0", {31'b0, pin_out}, 32'd1);
      wr(8'h02, 32'd5);
      for (int k = 1; k <= 10; k++) begin
         check($sformatf("upd_pin_%0d", k), {31'b0, pin_out}, (k < 3 || k >= 8) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // Address decode
      wr(8'h00, 32'd0);
      bus({3'b000, BASE + 8'h01, 8'h01}, 32'd7, 1'b1, 1'b1, 1'b0);
      bus({3'b000, BASE + 8'h01, 8'h00}, 32'd2, 1'b1, 1'b1, 1'b0);
      check("dec_page_oe", {31'b0, pin_oe}, 32'd0);
      bus(19'h0FFFF, 32'd7, 1'b1, 1'b1, 1'b0);
      bus({3'b000, BASE, 8'h01}, 32'd7, 1'b0, 1'b1, 1'b0);
      wr(8'h07, 32'd7);
      rd_chk("dec_mode", 8'h00, 32'd0);
      rd_chk("dec_high", 8'h01, 32'd3);
      @(negedge clk);
      check("dec_valid_drop", {31'b0, rd_valid}, 32'd0);
      check("dec_data_hold",  rd_data,           32'd3);
      rd_chk("dec_low",  8'h02, 32'd5);
      rd_chk("dec_off7", 8'h07, 32'd0);
      bus({3'b111, BASE, 8'h02}, 32'd4, 1'b1, 1'b1, 1'b0);
      rd_chk("dec_upper_bits", 8'h02, 32'd4);

      // Simultaneous rd and wr acts as a write only
      bus({3'b000, BASE, 8'h00}, 32'd2, 1'b1, 1'b1, 1'b1);
      check("conf_oe",    {31'b0, pin_oe},   32'd1);
      check("conf_out",   {31'b0, pin_out},  32'd1);
      check("conf_valid", {31'b0, rd_valid}, 32'd0);

      // PERIODS wrap and CLR coinciding with a completion
      wr(8'h01, 32'd1);
      wr(8'h02, 32'd1);
      wr(8'h00, 32'd3);
      force dut.periods_q = 32'hFFFF_FFFF;
      rd_chk("wrap_pre0", 8'h11, 32'hFFFF_FFFF);
      release dut.periods_q;
      rd_chk("wrap_pre1", 8'h11, 32'hFFFF_FFFF);
      rd_chk("wrap_zero", 8'h11, 32'd0);
      wr(8'h03, 32'hDEAD_BEEF);
      rd_chk("clr_coincident", 8'h11, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
